div_iter_unit: RTL
==================

# div_iter_unit

Iterative radix-2 restoring divider serving the execute stage's DIV/DIVU start/ready handshake. It accepts a one-cycle start with two operands and a signed flag, and computes quotient and remainder over WIDTH cycles. It presents the results as LO/HI words alongside a one-cycle ready pulse. A flush cancels an in-flight division without producing a result.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only in IDLE or DONE.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start.
- dividend_i  in  WIDTH  rs operand; captured with start.
- divisor_i  in  WIDTH  rt operand; captured with start.
- cancel_i  in  1  flush/exception kill; priority over start.
- busy_o  out  1  high in ITER; EXE uses it to stall.
- ready_o  out  1  high exactly in DONE (one cycle per accepted start).
- lo_o  out  WIDTH  quotient; held until the next accepted start.
- hi_o  out  WIDTH  remainder; held until the next accepted start.

## Operation
- States: IDLE, ITER, DONE. Reset value: IDLE; busy_o=0, ready_o=0, lo_o=0, hi_o=0, counter=0.
- Start in IDLE or DONE with cancel_i=0:
  - Capture the sign flags, abs(dividend), abs(divisor) (abs only when signed_i), and the raw dividend.
  - Clear the partial remainder and set cnt=0. Go to ITER.
- ITER, each edge:
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor: rem −= divisor, quo[0] = 1.
  - cnt++.
- On the edge that performs step WIDTH−1:
  - Apply sign correction and register the results; go to DONE.
  - lo = neg(quo) if sign(dividend)^sign(divisor), else quo.
  - hi = neg(rem) if sign(dividend), else rem.
- DONE: ready_o=1 for one cycle. The next edge goes to IDLE, or back to ITER if start is accepted.
- Start while in ITER is ignored.
- cancel_i=1 on any edge: go to IDLE. No ready; lo_o/hi_o keep their previous values.
- Divisor zero: lo = all ones, hi = raw dividend, for both signed and unsigned.
- Signed overflow (most-negative / −1): lo = 0x8000_0000, hi = 0. Arithmetic is modulo 2^WIDTH with no trap.
- Reset deasserted mid-operation is not special; asserting reset at any time forces IDLE immediately.

## Timing
- Start sampled at edge E0, ITER over E1..E(WIDTH), and the result registers at E(WIDTH) (edge 32 for the default).
- ready_o is high in the cycle following E(WIDTH). Latency start→ready = WIDTH cycles.
- busy_o is high in the cycles following E0..E(WIDTH−1) and low during DONE.
- Back-to-back: start in the DONE cycle yields the next ready WIDTH cycles later; no idle bubble.
- cancel_i and start_i both high on the same edge: cancel wins; state goes to IDLE.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - A start with divisor_i==0 goes directly to DONE at E0, with the divide-by-zero result.
  - ready_o is high in the cycle after E0, and busy_o never rises.
- Undefined: a zero divisor runs the full WIDTH iterations and then produces the same forced result.

## Structure
- div_pkg holds the state enum (IDLE/ITER/DONE), the counter width $clog2(WIDTH+1), and a neg/abs helper function.
- One sub-module, div_step: a combinational single restoring step, {rem, quo, divisor} → {rem', quo'}.
- The top level holds the FSM, counter, operand registers and sign fix.

## Test plan
- Unsigned 100 / 7: ready pulse at E0+32; lo=14, hi=2; busy high for 32 cycles.
- Signed −7 / 2: lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. Signed 7 / −2: lo=0xFFFF_FFFD, hi=1.
- Signed 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
- Divide by zero, 0x1234 / 0:
  - lo=0xFFFF_FFFF, hi=0x1234.
  - With DIV_ZERO_FAST_EN: ready at E0+1. Without: ready at E0+32.
- Cancel at E0+10: no ready; busy low after that edge; lo/hi unchanged. A new 9/3 then yields lo=3, hi=0 at 32 cycles.
- Start re-pulsed during ITER is ignored. rst low at E0+5 puts all outputs at reset values immediately.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;

    // Widest operand the sign helper handles; callers truncate back to WIDTH.
    localparam int HELPER_W = 64;

    // Step counter must hold 0..WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Two's complement negate when en is set, pass-through otherwise.
    // Used both for abs() on capture and for the final sign correction.
    function automatic logic [HELPER_W-1:0] cond_neg(input logic [HELPER_W-1:0] x,
                                                     input logic                en);
        return en ? ((~x) + {{(HELPER_W-1){1'b0}}, 1'b1}) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, subtract divisor if it fits.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_i/quo_i/div_i current partial state, rem_o/quo_o next partial state.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // The shifted remainder needs one extra bit: rem < divisor before the
    // shift, so 2*rem+1 can exceed WIDTH bits.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        fits   = (rem_sh >= {1'b0, div_i});
        // Only consumed when fits, so the modular WIDTH-bit difference is exact.
        diff   = rem_sh[WIDTH-1:0] - div_i;
        if (fits) begin
            rem_o = diff;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring DIV/DIVU: lo_o = quotient, hi_o = remainder.
// Latency: WIDTH cycles start->ready_o (1 cycle for a zero divisor with DIV_ZERO_FAST_EN).
// Backpressure: none; busy_o stalls the requester, start_i ignored while busy, cancel_i kills.
// Ports: clk, rst (async active-low), start_i/signed_i/dividend_i/divisor_i request,
//        cancel_i flush, busy_o/ready_o status, lo_o/hi_o results held until next start.
// Option: define DIV_ZERO_FAST_EN to finish a zero-divisor request in one cycle.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;     // |divisor|
    logic [WIDTH-1:0] raw_q, raw_d;     // dividend as given, for the /0 result
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             start_acc;
    logic             last_step;
    logic             dvs_in_zero;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    assign start_acc   = start_i && !cancel_i && (state_q != ITER);
    assign last_step   = (state_q == ITER) && (cnt_q == CW'(WIDTH - 1));
    assign dvs_in_zero = (divisor_i == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cancel overrides everything
    always_comb begin
        state_d = state_q;
        if (cancel_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
                        state_d = dvs_in_zero ? DONE : ITER;
`else
                        state_d = ITER;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                ITER: begin
                    if (last_step) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy_o  = (state_q == ITER);
        ready_o = (state_q == DONE);
        lo_o    = lo_q;
        hi_o    = hi_q;
    end

    // Datapath: capture on start, one step per ITER cycle, sign fix on the last
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        raw_d     = raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        lo_d      = lo_q;
        hi_d      = hi_q;

        if (start_acc) begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = WIDTH'(cond_neg(HELPER_W'(dividend_i), signed_i & dividend_i[WIDTH-1]));
            dvs_d     = WIDTH'(cond_neg(HELPER_W'(divisor_i),  signed_i & divisor_i[WIDTH-1]));
            raw_d     = dividend_i;
            neg_quo_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_rem_d = signed_i & dividend_i[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
            if (dvs_in_zero) begin
                lo_d = '1;
                hi_d = dividend_i;
            end
`endif
        end else if ((state_q == ITER) && !cancel_i) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
                // abs(divisor)==0 only for a zero divisor; force the fixed
                // result rather than sign-correcting the degenerate quotient.
                if (dvs_q == '0) begin
                    lo_d = '1;
                    hi_d = raw_q;
                end else begin
                    lo_d = WIDTH'(cond_neg(HELPER_W'(step_quo), neg_quo_q));
                    hi_d = WIDTH'(cond_neg(HELPER_W'(step_rem), neg_rem_q));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            raw_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            raw_q     <= raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
        end
    end

endmodule
